// File: rtl/d_debounce_pkg.sv
// Shared definitions for the d_debounce input conditioner: FSM encoding and default sizing.
package d_debounce_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        RISE_CHK    = 2'd1,
        HIGH_STABLE = 2'd2,
        FALL_CHK    = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 3;

    // The counter only needs to reach STABLE_CYCLES-1, never beyond.
    function automatic bit cnt_w_ok(input int w, input int stable);
        return (2 ** w) > (stable - 1);
    endfunction

endpackage

// File: rtl/d_debounce_sync_chain.sv
// Multi-flop synchroniser for asynchronous level inputs; reset clears every stage to 0.
module sync_chain
    import d_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic d_sync
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d_async};
        end
    end

    assign d_sync = ff[SYNC_STAGES-1];

endmodule

// File: rtl/d_debounce.sv
// Debouncer: synchronises d_raw, qualifies level changes over STABLE_CYCLES samples,
// and drives a registered clean level plus one-cycle rise/fall strobes.
//
// state       | meaning
// ------------+----------------------------------------------
// LOW_STABLE  | d_clean=0 accepted, waiting for a 1 sample
// RISE_CHK    | qualifying a candidate 0->1 change
// HIGH_STABLE | d_clean=1 accepted, waiting for a 0 sample
// FALL_CHK    | qualifying a candidate 1->0 change
module d_debounce
    import d_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic d_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("d_debounce: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("d_debounce: STABLE_CYCLES must be >= 2");
    end
    if (!cnt_w_ok(CNT_W, STABLE_CYCLES)) begin : g_bad_cnt_w
        $error("d_debounce: CNT_W too narrow for STABLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             d_sync;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             clean_nxt, rise_nxt, fall_nxt;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (d_raw),
        .d_sync  (d_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOW_STABLE;
            cnt     <= '0;
            d_clean <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            d_clean <= clean_nxt;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
        end
    end

    // The first differing sample loads cnt=1, so acceptance happens on the
    // STABLE_CYCLES-th consecutive differing sample.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clean_nxt = d_clean;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            LOW_STABLE: begin
                if (d_sync) begin
                    state_nxt = RISE_CHK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RISE_CHK: begin
                if (!d_sync) begin
                    state_nxt = LOW_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH_STABLE;
                    cnt_nxt   = '0;
                    clean_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                if (!d_sync) begin
                    state_nxt = FALL_CHK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            FALL_CHK: begin
                if (d_sync) begin
                    state_nxt = HIGH_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW_STABLE;
                    cnt_nxt   = '0;
                    clean_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = LOW_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state == RISE_CHK) || (state == FALL_CHK);
    end

endmodule

// File: tb/tb_d_debounce.sv
// Bench for d_debounce: directed vector table, corner sequences and random stimulus
// against a run-length reference model.
module tb_d_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst;
    logic d_raw;
    logic d_clean, rise, fall, busy;

    always #4 clk = ~clk;

    d_debounce dut (
        .clk     (clk),
        .rst     (rst),
        .d_raw   (d_raw),
        .d_clean (d_clean),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: raw samples reach the filter SYNC edges later; a new level is accepted
    // once STABLE consecutive filter samples differ from the accepted level.
    bit mq[$];
    int run;
    bit m_clean, m_rise, m_fall;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
        run     = 0;
        m_clean = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
    endfunction

    function automatic void model_step(input bit raw);
        bit seen;
        seen = mq.pop_front();
        mq.push_back(raw);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (seen != m_clean) begin
            run++;
            if (run == STABLE) begin
                m_clean = seen;
                m_rise  = seen;
                m_fall  = !seen;
                run     = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    function automatic logic [3:0] outs();
        return {d_clean, rise, fall, busy};
    endfunction

    function automatic logic [3:0] mvec();
        return {m_clean, m_rise, m_fall, (run > 0)};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual{clean,rise,fall,busy}=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare on the falling edge.
    task automatic cycle(input bit r, input bit raw);
        rst   = r;
        d_raw = raw;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(raw);
        @(negedge clk);
        check("model", outs(), mvec());
    endtask

    typedef struct {
        bit         r;
        bit         raw;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit raw, input logic [3:0] exp);
        vec_t v;
        v.r   = r;
        v.raw = raw;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        int rises, falls, len;
        bit lvl;

        rst   = 1'b1;
        d_raw = 1'b1;
        model_reset();
        #1;
        check("rst_initial", outs(), 4'b0000);

        // {clean, rise, fall, busy}
        add(1, 1, 4'b0000); add(1, 1, 4'b0000);
        add(0, 0, 4'b0000); add(0, 0, 4'b0000); add(0, 0, 4'b0000);
        add(0, 1, 4'b0000); add(0, 1, 4'b0000); add(0, 1, 4'b0001);
        add(0, 1, 4'b0001); add(0, 1, 4'b0001); add(0, 1, 4'b1100);
        add(0, 1, 4'b1000);
        add(0, 0, 4'b1000); add(0, 0, 4'b1000); add(0, 0, 4'b1001);
        add(0, 0, 4'b1001); add(0, 0, 4'b1001); add(0, 0, 4'b0010);
        add(0, 0, 4'b0000);
        add(0, 1, 4'b0000); add(0, 1, 4'b0000); add(0, 0, 4'b0001);
        add(0, 0, 4'b0001); add(0, 0, 4'b0000); add(0, 0, 4'b0000);
        add(0, 0, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].raw);
            check($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
        end

        // Restart: high 3, low 1, then high held; only the second run qualifies.
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, (i != 3));
            if (rise) rises++;
            if (i == 8) check("restart_e9", {d_clean, rise}, {1'b0, 1'b0});
            if (i == 9) check("restart_e10", {d_clean, rise}, {1'b1, 1'b1});
        end
        check("restart_rises", 4'(rises), 4'd1);

        // Clean fall, exactly one strobe.
        falls = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1'b0);
            if (fall) falls++;
            if (i == 4) check("fall_e5", {d_clean, fall}, {1'b1, 1'b0});
            if (i == 5) check("fall_e6", {d_clean, fall}, {1'b0, 1'b1});
        end
        check("fall_count", 4'(falls), 4'd1);

        // Reset while RISE_CHK with cnt=2 acts immediately; qualification restarts after release.
        for (int i = 0; i < 4; i++) cycle(0, 1'b1);
        check("pre_rst_busy", {d_clean, busy}, {1'b0, 1'b1});
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid", outs(), 4'b0000);
        cycle(1, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            cycle(0, 1'b1);
            if (i == 5) check("rst_restart_e5", outs(), 4'b0001);
            if (i == 6) check("rst_restart_e6", outs(), 4'b1100);
        end

        // Reset from HIGH_STABLE clears d_clean immediately.
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_high", outs(), 4'b0000);
        cycle(1, 1'b0);

        // Random level runs of varied length with occasional resets.
        for (int n = 0; n < 400; n++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                cycle(($urandom_range(0, 99) == 0), lvl);
                if (rise && fall) check("strobe_excl", {rise, fall, 2'b00}, 4'b0000);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
